// File: rtl/rf_wport_arbiter_if.sv
// rtl/rf_wport_arbiter_if.sv - pipe/aux request, RF write and trace bundle for rf_wport_arbiter
interface rf_wport_arbiter_if;
   logic        pipe_valid;
   logic        pipe_ready;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic [31:0] pipe_pc;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_waddr;
   logic [31:0] aux_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] aux_pend_mask;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   modport slave (
      input  pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
      input  aux_valid, aux_waddr, aux_wdata,
      output pipe_ready, aux_ready,
      output rf_we, rf_waddr, rf_wdata, aux_pend_mask,
      output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
   );

   modport master (
      output pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
      output aux_valid, aux_waddr, aux_wdata,
      input  pipe_ready, aux_ready,
      input  rf_we, rf_waddr, rf_wdata, aux_pend_mask,
      input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - GPR write-port arbiter: pipe priority, queued aux results, starvation guard
// Optional RF_WPORT_PEND_EN builds the per-GPR pending mask for queued aux writes.
module rf_wport_arbiter #(
   parameter int AUX_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                resetn,
   rf_wport_arbiter_if.slave   bus
);

   localparam int PW = $clog2(AUX_DEPTH);
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [4:0]    fifo_waddr [AUX_DEPTH];
   logic [31:0]   fifo_wdata [AUX_DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] rd_idx;
   logic          empty;
   logic          full;
   logic          push;
   logic          pipe_wr;
   logic          aux_grant;
   logic          pipe_accept;
   logic [CW-1:0] starve_cnt;
   logic          starved;

   logic          rf_we_q;
   logic [4:0]    rf_waddr_q;
   logic [31:0]   rf_wdata_q;
   logic [31:0]   wb_pc_q;

   assign wr_idx      = wr_ptr[PW-1:0];
   assign rd_idx      = rd_ptr[PW-1:0];
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_idx == rd_idx) && (wr_ptr[PW] != rd_ptr[PW]);
   assign starved     = (starve_cnt == CW'(STARVE_MAX));

   // Grant looks only at registered FIFO state, so a same-cycle push is never bypassed.
   assign pipe_wr     = bus.pipe_valid & bus.pipe_we;
   assign aux_grant   = ~empty & (~pipe_wr | starved);
   assign pipe_accept = bus.pipe_valid & ~(aux_grant & pipe_wr);
   assign push        = bus.aux_valid & ~full;

   assign bus.pipe_ready = ~(aux_grant & pipe_wr);
   assign bus.aux_ready  = ~full;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < AUX_DEPTH; i++) begin
            fifo_waddr[i] <= '0;
            fifo_wdata[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_waddr[wr_idx] <= bus.aux_waddr;
            fifo_wdata[wr_idx] <= bus.aux_wdata;
            wr_ptr             <= wr_ptr + 1'b1;
         end
         if (aux_grant) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Counts consecutive pipe wins only while aux work is waiting.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (empty || aux_grant) begin
         starve_cnt <= '0;
      end else if (pipe_wr && !starved) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_pc_q    <= '0;
      end else if (aux_grant) begin
         rf_we_q    <= (fifo_waddr[rd_idx] != 5'd0);
         rf_waddr_q <= fifo_waddr[rd_idx];
         rf_wdata_q <= fifo_wdata[rd_idx];
         wb_pc_q    <= 32'hFFFF_FFFF;
      end else if (pipe_accept) begin
         wb_pc_q <= bus.pipe_pc;
         if (pipe_wr) begin
            rf_we_q    <= (bus.pipe_waddr != 5'd0);
            rf_waddr_q <= bus.pipe_waddr;
            rf_wdata_q <= bus.pipe_wdata;
         end else begin
            rf_we_q <= 1'b0;
         end
      end else begin
         rf_we_q <= 1'b0;
      end
   end

   assign bus.rf_we             = rf_we_q;
   assign bus.rf_waddr          = rf_waddr_q;
   assign bus.rf_wdata          = rf_wdata_q;
   assign bus.debug_wb_pc       = wb_pc_q;
   assign bus.debug_wb_rf_we    = {4{rf_we_q}};
   assign bus.debug_wb_rf_wnum  = rf_waddr_q;
   assign bus.debug_wb_rf_wdata = rf_wdata_q;

`ifdef RF_WPORT_PEND_EN
   logic [PW:0]   occupancy;
   logic [PW-1:0] slot;
   logic [31:0]   pend;

   assign occupancy = wr_ptr - rd_ptr;

   always_comb begin
      pend = '0;
      slot = '0;
      for (int i = 0; i < AUX_DEPTH; i++) begin
         slot = rd_idx + PW'(i);
         if ((PW+1)'(i) < occupancy) begin
            pend[fifo_waddr[slot]] = 1'b1;
         end
      end
      pend[0] = 1'b0;
   end

   assign bus.aux_pend_mask = pend;
`else
   assign bus.aux_pend_mask = 32'h0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed scoreboard bench for rf_wport_arbiter
module tb_rf_wport_arbiter;
   localparam int DEPTH = 2;
   localparam int SM    = 4;

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] pc;
   } rf_t;

   logic clk;
   logic resetn;
   rf_wport_arbiter_if bus();

   rf_wport_arbiter #(.AUX_DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   rf_t         exp_q [$];
   logic [4:0]  mq_a [$];
   logic [31:0] mq_d [$];
   int          m_starve;
   rf_t         m_rf;
   logic        obs_pr;
   logic        obs_ar;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drv_pipe(input logic v, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] pc);
      bus.pipe_valid = v;
      bus.pipe_we    = we;
      bus.pipe_waddr = a;
      bus.pipe_wdata = d;
      bus.pipe_pc    = pc;
   endtask

   task automatic drv_aux(input logic v, input logic [4:0] a, input logic [31:0] d);
      bus.aux_valid = v;
      bus.aux_waddr = a;
      bus.aux_wdata = d;
   endtask

   task automatic model_reset();
      exp_q.delete();
      mq_a.delete();
      mq_d.delete();
      m_starve = 0;
      m_rf = '{we: 1'b0, a: 5'd0, d: 32'd0, pc: 32'd0};
   endtask

   // One clock: check handshakes mid-cycle, predict the registered outputs, check after the edge.
   task automatic cyc();
      logic        m_pwr;
      logic        m_grant;
      logic        m_empty;
      logic        e_pr;
      logic        e_ar;
      logic [31:0] e_mask;
      rf_t         nx;
      rf_t         got;
      @(negedge clk);
      m_empty = (mq_a.size() == 0);
      m_pwr   = bus.pipe_valid & bus.pipe_we;
      m_grant = !m_empty && (!m_pwr || m_starve == SM);
      e_pr    = !(m_grant && m_pwr);
      e_ar    = (mq_a.size() < DEPTH);
      e_mask  = 32'h0;
`ifdef RF_WPORT_PEND_EN
      foreach (mq_a[i]) if (mq_a[i] != 5'd0) e_mask[mq_a[i]] = 1'b1;
`endif
      obs_pr = bus.pipe_ready;
      obs_ar = bus.aux_ready;
      check("pipe_ready", {31'd0, bus.pipe_ready}, {31'd0, e_pr});
      check("aux_ready", {31'd0, bus.aux_ready}, {31'd0, e_ar});
      check("aux_pend_mask", bus.aux_pend_mask, e_mask);

      nx    = m_rf;
      nx.we = 1'b0;
      if (m_grant) begin
         nx.we = (mq_a[0] != 5'd0);
         nx.a  = mq_a[0];
         nx.d  = mq_d[0];
         nx.pc = 32'hFFFF_FFFF;
      end else if (bus.pipe_valid) begin
         nx.pc = bus.pipe_pc;
         if (m_pwr) begin
            nx.we = (bus.pipe_waddr != 5'd0);
            nx.a  = bus.pipe_waddr;
            nx.d  = bus.pipe_wdata;
         end
      end
      exp_q.push_back(nx);

      if (m_empty || m_grant) m_starve = 0;
      else if (m_pwr && m_starve < SM) m_starve++;
      if (m_grant) begin
         void'(mq_a.pop_front());
         void'(mq_d.pop_front());
      end
      if (bus.aux_valid && e_ar) begin
         mq_a.push_back(bus.aux_waddr);
         mq_d.push_back(bus.aux_wdata);
      end

      @(posedge clk);
      #1;
      got  = exp_q.pop_front();
      m_rf = got;
      check("rf_we", {31'd0, bus.rf_we}, {31'd0, got.we});
      check("rf_waddr", {27'd0, bus.rf_waddr}, {27'd0, got.a});
      check("rf_wdata", bus.rf_wdata, got.d);
      check("debug_wb_pc", bus.debug_wb_pc, got.pc);
      check("debug_wb_rf_we", {28'd0, bus.debug_wb_rf_we}, {28'd0, {4{got.we}}});
      check("debug_wb_rf_wnum", {27'd0, bus.debug_wb_rf_wnum}, {27'd0, got.a});
      check("debug_wb_rf_wdata", bus.debug_wb_rf_wdata, got.d);
   endtask

   initial begin
      int k;
      int low_idx;
      drv_pipe(0, 0, 0, 0, 0);
      drv_aux(0, 0, 0);
      model_reset();
      resetn = 1'b0;
      #2;
      check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
      check("rst_rf_wdata", bus.rf_wdata, 32'd0);
      check("rst_wb_pc", bus.debug_wb_pc, 32'd0);
      check("rst_aux_ready", {31'd0, bus.aux_ready}, 32'd1);
      check("rst_pend", bus.aux_pend_mask, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc();

      // Pipe-only write
      drv_pipe(1, 1, 5'd5, 32'h1234, 32'h0000_1000);
      cyc();
      check("t1_rf_we", {31'd0, bus.rf_we}, 32'd1);
      check("t1_dbg_we", {28'd0, bus.debug_wb_rf_we}, 32'hF);
      check("t1_ready", {31'd0, obs_pr}, 32'd1);
      // Non-writing retire still updates the trace pc
      drv_pipe(1, 0, 5'd6, 32'h5555, 32'h0000_1004);
      cyc();
      drv_pipe(0, 0, 0, 0, 0);
      cyc();

      // Aux with idle pipe: write lands two edges after the push
      drv_aux(1, 5'd7, 32'hAA);
      cyc();
      drv_aux(0, 0, 0);
`ifdef RF_WPORT_PEND_EN
      check("t2_pend7", {31'd0, bus.aux_pend_mask[7]}, 32'd1);
`endif
      check("t2_not_yet", {31'd0, bus.rf_we}, 32'd0);
      cyc();
      check("t2_rf_waddr", {27'd0, bus.rf_waddr}, 32'd7);
      check("t2_rf_wdata", bus.rf_wdata, 32'hAA);
      cyc();

      // Starvation: one queued aux entry against a saturating pipe
      k = 0;
      low_idx = -1;
      drv_aux(1, 5'd9, 32'h99);
      drv_pipe(1, 1, 5'd3, 32'h3000, 32'h2000);
      for (int i = 0; i < 9; i++) begin
         cyc();
         drv_aux(0, 0, 0);
         if (obs_pr) begin
            k++;
            drv_pipe(1, 1, 5'd3, 32'h3000 + k, 32'h2000 + 4 * k);
         end else if (low_idx < 0) begin
            low_idx = i;
         end
      end
      check("t3_starve_slot", low_idx, 32'd5);
      check("t3_pipe_wins", k, 32'd8);

      // Full FIFO while the pipe saturates
      low_idx = -1;
      for (int i = 0; i < 12; i++) begin
         if (i < 3) drv_aux(1, 5'(20 + i), 32'hA0 + i);
         else       drv_aux(0, 0, 0);
         if (i == 2) drv_aux(1, 5'd22, 32'hDEAD);
         cyc();
         if (i == 2) check("t4_full", {31'd0, obs_ar}, 32'd0);
         if (obs_pr) begin
            k++;
            drv_pipe(1, 1, 5'd4, 32'h4000 + k, 32'h3000 + 4 * k);
         end else if (low_idx < 0) begin
            low_idx = i;
         end
         if (i == 5) check("t4_ready_after_pop_pending", {31'd0, obs_ar}, 32'd0);
      end
      check("t4_first_pop", low_idx, 32'd5);
      drv_aux(0, 0, 0);
      drv_pipe(0, 0, 0, 0, 0);
      cyc();
      check("t4_ready_after_pop", {31'd0, obs_ar}, 32'd1);

      // Push and pop in the same cycle
      drv_aux(1, 5'd12, 32'hC0);
      cyc();
      drv_aux(1, 5'd13, 32'hC1);
      cyc();
      drv_aux(0, 0, 0);
      cyc();
      cyc();

      // r0 is never written, from either source
      drv_pipe(1, 1, 5'd0, 32'hBAD0, 32'h4000);
      drv_aux(1, 5'd0, 32'hBAD1);
      cyc();
      check("t5_r0_ready", {31'd0, obs_pr}, 32'd1);
      check("t5_r0_we", {31'd0, bus.rf_we}, 32'd0);
      drv_pipe(0, 0, 0, 0, 0);
      drv_aux(0, 0, 0);
      cyc();
      check("t5_r0_aux_we", {31'd0, bus.rf_we}, 32'd0);
      cyc();

      // Reset with two entries queued
      drv_pipe(1, 1, 5'd4, 32'h5000, 32'h5000);
      drv_aux(1, 5'd10, 32'hD0);
      cyc();
      drv_aux(1, 5'd11, 32'hD1);
      cyc();
      drv_aux(0, 0, 0);
      resetn = 1'b0;
      #1;
      check("rst2_rf_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst2_pend", bus.aux_pend_mask, 32'd0);
      check("rst2_aux_ready", {31'd0, bus.aux_ready}, 32'd1);
      check("rst2_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
      check("rst2_wb_pc", bus.debug_wb_pc, 32'd0);
      drv_pipe(0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc();
      cyc();
      drv_pipe(1, 1, 5'd31, 32'hFFFF_0001, 32'h6000);
      cyc();
      drv_pipe(0, 0, 0, 0, 0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
